// File: rtl/pipe_ctrl_unit.sv
// Five-stage pipeline control sequencer: stage control registers, stalls, flushes, forwarding and trap FSM.
// Define PIPE_CTRL_FWD_EN to enable EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall until WB.
module pipe_ctrl_unit #(
  parameter int CW_WIDTH = 20,
  parameter int REG_AW   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [CW_WIDTH-1:0] id_ctrl,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_r1_used,
  input  logic                id_r2_used,
  input  logic                id_ecall,
  input  logic                id_uret,
  input  logic                irq_req,
  input  logic                ex_redirect,
  output logic                stall_if,
  output logic                stall_id,
  output logic                flush_id,
  output logic [CW_WIDTH-1:0] ex_ctrl,
  output logic [CW_WIDTH-1:0] mem_ctrl,
  output logic [CW_WIDTH-1:0] wb_ctrl,
  output logic [REG_AW-1:0]   ex_rd,
  output logic [REG_AW-1:0]   mem_rd,
  output logic [REG_AW-1:0]   wb_rd,
  output logic                ex_valid,
  output logic                mem_valid,
  output logic                wb_valid,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                trap_take,
  output logic                trap_ret,
  output logic [1:0]          trap_cause
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TRAP} state_t;

  state_t     state;
  logic [1:0] pend_cause;
  logic [1:0] cause_nxt;
  logic       ex_wr, mem_wr, ex_hit, load_use, hazard;
  logic       trigger, issue, pipe_empty;

  assign ex_wr    = ex_valid & ex_ctrl[0];
  assign mem_wr   = mem_valid & mem_ctrl[0];
  assign ex_hit   = (ex_rd != '0) &
                    ((id_r1_used & (id_rs1 == ex_rd)) | (id_r2_used & (id_rs2 == ex_rd)));
  assign load_use = ex_valid & ex_ctrl[1] & ex_ctrl[0] & ex_hit;

`ifdef PIPE_CTRL_FWD_EN
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  assign hazard = load_use;

  // Selects are computed for the instruction entering EX: today's EX becomes MEM, today's MEM becomes WB.
  assign fwd_a_nxt = (ex_wr && ex_rd != '0 && ex_rd == id_rs1)    ? 2'b01 :
                     (mem_wr && mem_rd != '0 && mem_rd == id_rs1) ? 2'b10 : 2'b00;
  assign fwd_b_nxt = (ex_wr && ex_rd != '0 && ex_rd == id_rs2)    ? 2'b01 :
                     (mem_wr && mem_rd != '0 && mem_rd == id_rs2) ? 2'b10 : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      fwd_a <= issue ? fwd_a_nxt : 2'b00;
      fwd_b <= issue ? fwd_b_nxt : 2'b00;
    end
  end
`else
  logic mem_hit;

  assign mem_hit = (mem_rd != '0) &
                   ((id_r1_used & (id_rs1 == mem_rd)) | (id_r2_used & (id_rs2 == mem_rd)));
  assign hazard  = load_use | (ex_wr & ex_hit) | (mem_wr & mem_hit);
  assign fwd_a   = 2'b00;
  assign fwd_b   = 2'b00;
`endif

  assign trigger    = (state == S_RUN) & id_valid & (irq_req | id_ecall | id_uret) & ~ex_redirect;
  assign issue      = (state == S_RUN) & id_valid & ~hazard & ~ex_redirect & ~trigger;
  assign pipe_empty = ~ex_valid & ~mem_valid & ~wb_valid;
  assign cause_nxt  = irq_req ? 2'b10 : (id_ecall ? 2'b01 : 2'b11);

  // Redirect always wins over stalls; outputs are forced low while reset is held.
  assign stall_if = ~rst & ~ex_redirect & ((state == S_DRAIN) | ((state == S_RUN) & hazard));
  assign stall_id = stall_if;
  assign flush_id = ~rst & (ex_redirect | (state == S_TRAP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
      wb_rd     <= '0;
    end else begin
      ex_valid  <= issue;
      ex_ctrl   <= issue ? id_ctrl : '0;
      ex_rd     <= issue ? id_rd : '0;
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl;
      mem_rd    <= ex_rd;
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl;
      wb_rd     <= mem_rd;
    end
  end

  // The pending cause is kept apart from trap_cause so an aborted drain leaves the last reported cause intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RUN;
      pend_cause <= 2'b00;
      trap_cause <= 2'b00;
      trap_take  <= 1'b0;
      trap_ret   <= 1'b0;
    end else begin
      trap_take <= 1'b0;
      trap_ret  <= 1'b0;
      case (state)
        S_RUN: begin
          if (trigger) begin
            pend_cause <= cause_nxt;
            state      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ex_redirect) begin
            pend_cause <= 2'b00;
            state      <= S_RUN;
          end else if (pipe_empty) begin
            trap_cause <= pend_cause;
            trap_take  <= (pend_cause != 2'b11);
            trap_ret   <= (pend_cause == 2'b11);
            pend_cause <= 2'b00;
            state      <= S_TRAP;
          end
        end
        S_TRAP:  state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed test-plan steps followed by random traffic,
// all checked against a queue-based pipeline model that honours PIPE_CTRL_FWD_EN.
module tb_pipe_ctrl_unit;

  localparam int CW = 20;
  localparam int AW = 5;

  localparam logic [CW-1:0] C_ADD = 20'hA5001;
  localparam logic [CW-1:0] C_SUB = 20'h3C001;
  localparam logic [CW-1:0] C_LW  = 20'h12003;

`ifdef PIPE_CTRL_FWD_EN
  localparam int         T2_STALLS = 1;
  localparam int         T3_STALLS = 0;
  localparam logic [1:0] T2_FWD    = 2'b10;
  localparam logic [1:0] T3_FWD    = 2'b01;
`else
  localparam int         T2_STALLS = 2;
  localparam int         T3_STALLS = 2;
  localparam logic [1:0] T2_FWD    = 2'b00;
  localparam logic [1:0] T3_FWD    = 2'b00;
`endif

  logic clk, rst;
  logic id_valid, id_r1_used, id_r2_used, id_ecall, id_uret, irq_req, ex_redirect;
  logic [CW-1:0] id_ctrl;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic stall_if, stall_id, flush_id;
  logic [CW-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic ex_valid, mem_valid, wb_valid;
  logic [1:0] fwd_a, fwd_b, trap_cause;
  logic trap_take, trap_ret;

  pipe_ctrl_unit #(.CW_WIDTH(CW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
    .id_ecall(id_ecall), .id_uret(id_uret), .irq_req(irq_req), .ex_redirect(ex_redirect),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .trap_take(trap_take), .trap_ret(trap_ret), .trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] rd;
    logic [1:0]    fa;
    logic [1:0]    fb;
  } stage_t;

  // Model: pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB.
  stage_t     pipe[$];
  bit         m_drain, m_trap;
  logic [1:0] m_pend, m_cause;

  int   n_vectors = 0;
  int   n_checks = 0;
  int   n_miscompares = 0;
  logic obs_stall, obs_flush;

  function automatic stage_t bubble();
    stage_t s;
    s.valid = 1'b0; s.ctrl = '0; s.rd = '0; s.fa = 2'b00; s.fb = 2'b00;
    return s;
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(bubble());
    m_drain = 0; m_trap = 0; m_pend = 2'b00; m_cause = 2'b00;
  endtask

  function automatic bit reads_reg(input logic [AW-1:0] r);
    return (r != '0) && ((id_r1_used && id_rs1 == r) || (id_r2_used && id_rs2 == r));
  endfunction

  function automatic bit hazard_now();
    bit h = 0;
`ifdef PIPE_CTRL_FWD_EN
    h = pipe[0].valid && pipe[0].ctrl[1] && pipe[0].ctrl[0] && reads_reg(pipe[0].rd);
`else
    for (int k = 0; k < 2; k++)
      if (pipe[k].valid && pipe[k].ctrl[0] && reads_reg(pipe[k].rd)) h = 1;
`endif
    return h;
  endfunction

  function automatic logic [1:0] src_for(input logic [AW-1:0] rs);
`ifdef PIPE_CTRL_FWD_EN
    for (int k = 0; k < 2; k++)
      if (pipe[k].valid && pipe[k].ctrl[0] && pipe[k].rd != '0 && pipe[k].rd == rs)
        return (k == 0) ? 2'b01 : 2'b10;
`endif
    return 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic bound_expired(input string tag);
    n_checks++;
    n_miscompares++;
    $error("[TB] FAIL %s: wait bound expired, observed no event expected one", tag);
  endtask

  // One clock: check everything against the model just before the edge, then advance the model.
  task automatic applyStimulus();
    bit hz, running, trig, iss, empty;
    bit e_stall, e_flush;
    stage_t nxt;
    logic [1:0] cause_new;
    #1;
    if (rst) model_reset();
    hz      = hazard_now();
    running = !m_drain && !m_trap;
    trig    = running && id_valid && (irq_req || id_ecall || id_uret) && !ex_redirect;
    iss     = running && id_valid && !hz && !ex_redirect && !trig;
    e_stall = !rst && !ex_redirect && (m_drain || (running && hz));
    e_flush = !rst && (ex_redirect || m_trap);
    checkOutput("stall_if",   32'(stall_if),   32'(e_stall));
    checkOutput("stall_id",   32'(stall_id),   32'(e_stall));
    checkOutput("flush_id",   32'(flush_id),   32'(e_flush));
    checkOutput("ex_valid",   32'(ex_valid),   32'(pipe[0].valid));
    checkOutput("ex_ctrl",    32'(ex_ctrl),    32'(pipe[0].ctrl));
    checkOutput("ex_rd",      32'(ex_rd),      32'(pipe[0].rd));
    checkOutput("mem_valid",  32'(mem_valid),  32'(pipe[1].valid));
    checkOutput("mem_ctrl",   32'(mem_ctrl),   32'(pipe[1].ctrl));
    checkOutput("mem_rd",     32'(mem_rd),     32'(pipe[1].rd));
    checkOutput("wb_valid",   32'(wb_valid),   32'(pipe[2].valid));
    checkOutput("wb_ctrl",    32'(wb_ctrl),    32'(pipe[2].ctrl));
    checkOutput("wb_rd",      32'(wb_rd),      32'(pipe[2].rd));
    checkOutput("fwd_a",      32'(fwd_a),      32'(pipe[0].fa));
    checkOutput("fwd_b",      32'(fwd_b),      32'(pipe[0].fb));
    checkOutput("trap_take",  32'(trap_take),  32'(m_trap && m_cause != 2'b11));
    checkOutput("trap_ret",   32'(trap_ret),   32'(m_trap && m_cause == 2'b11));
    checkOutput("trap_cause", 32'(trap_cause), 32'(m_cause));
    obs_stall = stall_id;
    obs_flush = flush_id;
    n_vectors++;
    empty = !pipe[0].valid && !pipe[1].valid && !pipe[2].valid;
    nxt = bubble();
    if (iss) begin
      nxt.valid = 1'b1; nxt.ctrl = id_ctrl; nxt.rd = id_rd;
      nxt.fa = src_for(id_rs1); nxt.fb = src_for(id_rs2);
    end
    cause_new = irq_req ? 2'b10 : (id_ecall ? 2'b01 : 2'b11);
    @(posedge clk);
    if (!rst) begin
      if (m_trap) m_trap = 0;
      else if (m_drain) begin
        if (ex_redirect) begin
          m_drain = 0; m_pend = 2'b00;
        end else if (empty) begin
          m_drain = 0; m_trap = 1; m_cause = m_pend; m_pend = 2'b00;
        end
      end else if (trig) begin
        m_drain = 1; m_pend = cause_new;
      end
      pipe.push_front(nxt);
      void'(pipe.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic nop();
    id_valid = 0; id_ctrl = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_r1_used = 0; id_r2_used = 0; id_ecall = 0; id_uret = 0; irq_req = 0; ex_redirect = 0;
  endtask

  task automatic instr(input logic [CW-1:0] c, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic u1, input logic u2);
    nop();
    id_valid = 1; id_ctrl = c; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_r1_used = u1; id_r2_used = u2;
  endtask

  // Hold the ID instruction until the model says it issued; count observed stall cycles.
  task automatic step_hold(output int stalls);
    bit done = 0;
    stalls = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      bit was_stall;
      was_stall = !m_drain && !m_trap && hazard_now() && !ex_redirect;
      applyStimulus();
      if (obs_stall === 1'b1) stalls++;
      if (!was_stall) done = 1;
    end
    if (!done) bound_expired("step_hold");
  endtask

  task automatic idle(input int n);
    nop();
    repeat (n) applyStimulus();
  endtask

  task automatic wait_trap(output int drain_cycles);
    bit seen = 0;
    drain_cycles = 0;
    nop();
    for (int i = 0; i < 10 && !seen; i++) begin
      applyStimulus();
      if (obs_stall === 1'b1) drain_cycles++;
      if (trap_take === 1'b1 || trap_ret === 1'b1) seen = 1;
    end
    if (!seen) bound_expired("wait_trap");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, d, pulses;
    nop();
    rst = 1;
    model_reset();
    @(negedge clk);
    ex_redirect = 1;
    applyStimulus();
    nop();
    applyStimulus();
    rst = 0;
    idle(1);

    // Plan 1: independent adds flow through EX/MEM/WB without stalls
    s = 0;
    instr(C_ADD, 5'd1, 5'd0, 5'd0, 1, 1); applyStimulus(); s += int'(obs_stall);
    checkOutput("t1_ex_ctrl", 32'(ex_ctrl), 32'(C_ADD));
    instr(C_SUB, 5'd2, 5'd0, 5'd0, 1, 1); applyStimulus(); s += int'(obs_stall);
    checkOutput("t1_mem_ctrl", 32'(mem_ctrl), 32'(C_ADD));
    instr(C_ADD, 5'd3, 5'd0, 5'd0, 1, 1); applyStimulus(); s += int'(obs_stall);
    checkOutput("t1_wb_ctrl", 32'(wb_ctrl), 32'(C_ADD));
    checkOutput("t1_stalls", 32'(s), 32'd0);
    idle(3);

    // Plan 2: load-use
    instr(C_LW, 5'd5, 5'd1, 5'd0, 1, 0); applyStimulus();
    instr(C_ADD, 5'd6, 5'd5, 5'd7, 1, 1); step_hold(s);
    checkOutput("t2_stalls", 32'(s), 32'(T2_STALLS));
    checkOutput("t2_fwd_a", 32'(fwd_a), 32'(T2_FWD));
    idle(3);

    // Plan 3: ALU-to-ALU dependence, then the same through x0
    instr(C_ADD, 5'd5, 5'd1, 5'd2, 1, 1); applyStimulus();
    instr(C_SUB, 5'd8, 5'd5, 5'd5, 1, 1); step_hold(s);
    checkOutput("t3_stalls", 32'(s), 32'(T3_STALLS));
    checkOutput("t3_fwd_a", 32'(fwd_a), 32'(T3_FWD));
    checkOutput("t3_fwd_b", 32'(fwd_b), 32'(T3_FWD));
    idle(3);
    instr(C_ADD, 5'd0, 5'd1, 5'd2, 1, 1); applyStimulus();
    instr(C_SUB, 5'd8, 5'd0, 5'd0, 1, 1); step_hold(s);
    checkOutput("t3_x0_stalls", 32'(s), 32'd0);
    checkOutput("t3_x0_fwd_a", 32'(fwd_a), 32'd0);
    idle(3);

    // Plan 4: ecall behind three instructions, then uret on an empty pipe
    for (int i = 1; i <= 3; i++) begin
      instr(C_ADD, 5'(i), 5'd0, 5'd0, 1, 1); applyStimulus();
    end
    instr('0, 5'd0, 5'd0, 5'd0, 0, 0); id_ecall = 1; applyStimulus();
    wait_trap(d);
    checkOutput("t4_drain", 32'(d), 32'd3);
    checkOutput("t4_take", 32'(trap_take), 32'd1);
    checkOutput("t4_cause", 32'(trap_cause), 32'd1);
    idle(1);
    checkOutput("t4_take_pulse", 32'(trap_take), 32'd0);
    instr('0, 5'd0, 5'd0, 5'd0, 0, 0); id_uret = 1; applyStimulus();
    wait_trap(d);
    checkOutput("t4_ret", 32'(trap_ret), 32'd1);
    checkOutput("t4_ret_cause", 32'(trap_cause), 32'd3);
    idle(2);

    // Plan 5: irq beats ecall; then a redirect during the drain aborts it
    instr('0, 5'd0, 5'd0, 5'd0, 0, 0); id_ecall = 1; irq_req = 1; applyStimulus();
    wait_trap(d);
    checkOutput("t5_cause", 32'(trap_cause), 32'd2);
    idle(2);
    instr(C_ADD, 5'd4, 5'd0, 5'd0, 1, 1); applyStimulus();
    instr('0, 5'd0, 5'd0, 5'd0, 0, 0); id_ecall = 1; irq_req = 1; applyStimulus();
    nop(); irq_req = 0; ex_redirect = 1; applyStimulus();
    checkOutput("t5_abort_flush", 32'(obs_flush), 32'd1);
    pulses = 0;
    nop();
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      pulses += int'(trap_take) + int'(trap_ret);
    end
    checkOutput("t5_abort_pulses", 32'(pulses), 32'd0);
    checkOutput("t5_abort_stall", 32'(obs_stall), 32'd0);

    // Plan 6: load-use coinciding with redirect
    instr(C_LW, 5'd5, 5'd1, 5'd0, 1, 0); applyStimulus();
    instr(C_ADD, 5'd6, 5'd5, 5'd7, 1, 1); ex_redirect = 1; applyStimulus();
    checkOutput("t6_stall", 32'(obs_stall), 32'd0);
    checkOutput("t6_flush", 32'(obs_flush), 32'd1);
    checkOutput("t6_ex_bubble", 32'(ex_valid), 32'd0);
    idle(3);

    // Asynchronous reset in the middle of a drain
    for (int i = 1; i <= 2; i++) begin
      instr(C_ADD, 5'(i), 5'd0, 5'd0, 1, 1); applyStimulus();
    end
    instr('0, 5'd0, 5'd0, 5'd0, 0, 0); id_ecall = 1; applyStimulus();
    idle(1);
    rst = 1; applyStimulus();
    checkOutput("rst_drain_stall", 32'(obs_stall), 32'd0);
    rst = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      pulses += int'(trap_take) + int'(trap_ret);
    end
    checkOutput("rst_drain_pulses", 32'(pulses), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      id_valid    = ($urandom_range(0, 9) != 0);
      id_ctrl     = CW'($urandom);
      id_rd       = AW'($urandom_range(0, 7));
      id_rs1      = AW'($urandom_range(0, 7));
      id_rs2      = AW'($urandom_range(0, 7));
      id_r1_used  = ($urandom_range(0, 3) != 0);
      id_r2_used  = ($urandom_range(0, 1) != 0);
      id_ecall    = ($urandom_range(0, 29) == 0);
      id_uret     = ($urandom_range(0, 39) == 0);
      irq_req     = ($urandom_range(0, 49) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    rst = 0;
    idle(4);

    $display("[TB] %0d comparisons made", n_checks);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
